tid_retire_tracker: RTL and testbench
=====================================

TID_RETIRE_TRACKER -- requirements
Module: tid_retire_tracker

Interface
REQ-001 SHALL have parameter TOTAL_TID, default 512, maximum number of thread IDs per launch; TW = $clog2(TOTAL_TID).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  arms tracker from IDLE; gates acceptance in COLLECT.
REQ-005 SHALL have port clr  input  1  synchronous clear to IDLE from any state.
REQ-006 SHALL have port max_tid  input  TW  highest TID of the launch (thread count = max_tid+1).
REQ-007 SHALL have port ret_valid  input  1  a retiring thread is presented.
REQ-008 SHALL have port ret_tid  input  TW  TID of the retiring thread.
REQ-009 SHALL have port ret_ready  output  1  tracker accepts a retirement this cycle.
REQ-010 SHALL have port ret_count  output  TW+1  number of distinct in-range TIDs retired.
REQ-011 SHALL have port all_done  output  1  every TID 0..max_tid has retired.
REQ-012 SHALL have port busy  output  1  state == COLLECT.
REQ-013 SHALL have port range_err  output  1  sticky: a TID > max_tid was presented.
REQ-014 SHALL have port dup_err  output  1  sticky: an already-retired TID was presented.

Function
REQ-015 SHALL implement states IDLE, COLLECT, DONE.
REQ-016 IDLE->COLLECT when enable=1; max_tid SHALL be latched on this transition, later changes ignored until next IDLE.
REQ-017 COLLECT->DONE on the cycle an accepted retirement makes ret_count reach latched max_tid+1; DONE SHALL hold until clr.
REQ-018 clr=1 SHALL force next state IDLE from any state and clear ret_count, retire bitmap, range_err, dup_err on the same edge; clr beats enable and a concurrent accept.
REQ-019 ret_ready SHALL be combinational = (state==COLLECT) && enable; accept = ret_valid && ret_ready.
REQ-020 On accept with ret_tid > latched max_tid: range_err<=1, ret_count and bitmap unchanged.
REQ-021 On accept with in-range TID whose bitmap bit is set: dup_err<=1, ret_count unchanged.
REQ-022 On accept with in-range, not-yet-retired TID: bitmap bit set, ret_count<=ret_count+1 (TW+1 bits; no wrap at max_tid=TOTAL_TID-1, reaches TOTAL_TID).
REQ-023 all_done SHALL equal (state==DONE), i.e. asserted the cycle after the final accept; busy SHALL equal (state==COLLECT).
REQ-024 Retirement order SHALL be arbitrary; one retirement per cycle maximum.
REQ-025 ret_valid outside COLLECT or with enable=0 SHALL be ignored (ret_ready=0, no flag change).
REQ-026 Entering COLLECT from IDLE SHALL start with ret_count=0 and empty bitmap.

Reset
REQ-027 rst_n low SHALL asynchronously set state=IDLE, ret_count=0, bitmap=0, range_err=0, dup_err=0; hence ret_ready=0, all_done=0, busy=0.
REQ-028 Reset mid-COLLECT SHALL discard all progress; no output retains pre-reset state.

Configuration
REQ-029 Macro TID_RETIRE_DUP_CHECK_EN defined: TOTAL_TID-bit bitmap present, REQ-021 duplicate detection active.
REQ-030 Macro undefined: no bitmap; every in-range accept increments ret_count, dup_err tied 0; completion is count-based only.

Structure
REQ-031 Shared package cgra_subsys_pkg SHALL hold the TID width localparam/typedef (tid_t) and the state enum type (retire_state_e).
REQ-032 Bitmap SHALL be a sub-module tid_retire_bitmap (set-by-index, test-by-index, synchronous clear), instantiated only under TID_RETIRE_DUP_CHECK_EN.

Verification
REQ-033 max_tid=3, enable=1, retire 2,0,3,1 back-to-back -> ret_count 1..4, all_done=1 cycle after 4th accept, errors 0.
REQ-034 max_tid=3, retire 1,1 (macro on) -> dup_err=1, ret_count=1, all_done=0; macro off -> ret_count=2, dup_err=0.
REQ-035 max_tid=3, retire TID 7 -> range_err=1 next cycle, ret_count=0, state COLLECT.
REQ-036 max_tid=7, retire 0..4, then clr with ret_valid=1 -> next cycle state IDLE, ret_count=0, errors 0, ret_ready=0.
REQ-037 Mid-COLLECT drop enable for 3 cycles with ret_valid=1 -> ret_ready=0, count frozen; resume -> continues.
REQ-038 TOTAL_TID=512, max_tid=511, retire all 512 TIDs -> ret_count=512, all_done=1; async rst_n pulse afterwards -> all outputs 0.

Source files
------------

// File: rtl/cgra_subsys_pkg.sv
// Purpose : shared types for the CGRA subsystem: TID width/type and retire-tracker state encoding.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package cgra_subsys_pkg;

    // Default launch size; the TID type is sized from it.
    localparam int TOTAL_TID_DEF = 512;
    localparam int TID_W         = $clog2(TOTAL_TID_DEF);

    typedef logic [TID_W-1:0] tid_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } retire_state_e;

endpackage

// File: rtl/tid_retire_bitmap.sv
// Purpose : one bit per TID recording which threads have already retired.
// Latency : set lands on the next clk edge; test_hit is combinational from the registered bits.
// Backpr. : none; a set is taken every cycle set_en is high, clr wins over set.
// Ports   : clk, rst_n (async active-low), clr (sync clear), set_en/set_idx (mark a TID),
//           test_idx/test_hit (query a TID).
module tid_retire_bitmap #(
    parameter  int N  = 512,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          set_en,
    input  logic [IW-1:0] set_idx,
    input  logic [IW-1:0] test_idx,
    output logic          test_hit
);

    logic [N-1:0] bits_q;
    logic [N-1:0] bits_d;

    always_comb begin
        bits_d = bits_q;
        if (clr) begin
            bits_d = '0;
        end else if (set_en) begin
            bits_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    assign test_hit = bits_q[test_idx];

endmodule

// File: rtl/tid_retire_tracker.sv
// Purpose : counts distinct retiring thread IDs of a launch and flags completion, out-of-range and
//           (when TID_RETIRE_DUP_CHECK_EN is defined) duplicate retirements.
// Latency : ret_ready combinational; count/flags/all_done update on the edge after an accept.
// Backpr. : ret_ready low outside COLLECT or while enable is low; at most one retirement per cycle.
// Ports   : clk, rst_n (async active-low), enable (arm / gate), clr (sync clear to IDLE),
//           max_tid (latched when arming), ret_valid/ret_tid/ret_ready (retire handshake),
//           ret_count, all_done, busy, range_err, dup_err (sticky status).
// Config  : TID_RETIRE_DUP_CHECK_EN adds the per-TID bitmap and duplicate detection; without it
//           every in-range accept counts and dup_err is tied low.
module tid_retire_tracker
    import cgra_subsys_pkg::*;
#(
    parameter  int TOTAL_TID = TOTAL_TID_DEF,
    localparam int TW        = $clog2(TOTAL_TID)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          clr,
    input  logic [TW-1:0] max_tid,
    input  logic          ret_valid,
    input  logic [TW-1:0] ret_tid,
    output logic          ret_ready,
    output logic [TW:0]   ret_count,
    output logic          all_done,
    output logic          busy,
    output logic          range_err,
    output logic          dup_err
);

    localparam logic [TW:0] ONE = {{TW{1'b0}}, 1'b1};

    retire_state_e state_q, state_d;
    logic [TW-1:0] max_q, max_d;
    logic [TW:0]   cnt_q, cnt_d;
    logic          rerr_q, rerr_d;

    logic accept;
    logic in_range;
    logic dup_hit;
    logic new_ret;

    assign ret_ready = (state_q == ST_COLLECT) && enable;
    assign accept    = ret_valid && ret_ready;
    assign in_range  = (ret_tid <= max_q);
    assign new_ret   = accept && in_range && !dup_hit;

`ifdef TID_RETIRE_DUP_CHECK_EN
    logic derr_q, derr_d;
    logic bm_clr;

    // Bitmap is also wiped while idle so every launch starts empty.
    assign bm_clr = clr || (state_q == ST_IDLE);

    tid_retire_bitmap #(
        .N (TOTAL_TID)
    ) u_bitmap (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bm_clr),
        .set_en   (new_ret),
        .set_idx  (ret_tid),
        .test_idx (ret_tid),
        .test_hit (dup_hit)
    );

    always_comb begin
        derr_d = derr_q;
        if (clr || (state_q == ST_IDLE)) begin
            derr_d = 1'b0;
        end else if (accept && in_range && dup_hit) begin
            derr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            derr_q <= 1'b0;
        end else begin
            derr_q <= derr_d;
        end
    end

    assign dup_err = derr_q;
`else
    assign dup_hit = 1'b0;
    assign dup_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        rerr_d  = rerr_q;

        case (state_q)
            ST_IDLE: begin
                // Hold progress at zero so arming always starts a clean launch.
                cnt_d  = '0;
                rerr_d = 1'b0;
                if (enable) begin
                    state_d = ST_COLLECT;
                    max_d   = max_tid;
                end
            end
            ST_COLLECT: begin
                if (accept && !in_range) begin
                    rerr_d = 1'b1;
                end
                if (new_ret) begin
                    cnt_d = cnt_q + ONE;
                    // Count is TW+1 wide so a full TOTAL_TID launch reaches TOTAL_TID without wrap.
                    if (cnt_d == ({1'b0, max_q} + ONE)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear beats arming and any concurrent accept.
        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rerr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            max_q   <= '0;
            cnt_q   <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            rerr_q  <= rerr_d;
        end
    end

    assign ret_count = cnt_q;
    assign all_done  = (state_q == ST_DONE);
    assign busy      = (state_q == ST_COLLECT);
    assign range_err = rerr_q;

endmodule

// File: tb/tb_tid_retire_tracker.sv
// Purpose : randomized + directed scoreboard bench for tid_retire_tracker against a launch-level model.
// Latency : expectation for a driven cycle is checked at the following negedge (ret_ready) and posedge+1.
// Backpr. : stimulus follows the model's view of ret_ready; the monitor never stalls the stimulus.
module tb_tid_retire_tracker;

    localparam int TOTAL = 512;
    localparam int TW    = 9;

`ifdef TID_RETIRE_DUP_CHECK_EN
    localparam bit DUP_ON = 1'b1;
`else
    localparam bit DUP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          clr;
    logic [TW-1:0] max_tid;
    logic          ret_valid;
    logic [TW-1:0] ret_tid;
    logic          ret_ready;
    logic [TW:0]   ret_count;
    logic          all_done;
    logic          busy;
    logic          range_err;
    logic          dup_err;

    always #5 clk = ~clk;

    tid_retire_tracker #(.TOTAL_TID(TOTAL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clr       (clr),
        .max_tid   (max_tid),
        .ret_valid (ret_valid),
        .ret_tid   (ret_tid),
        .ret_ready (ret_ready),
        .ret_count (ret_count),
        .all_done  (all_done),
        .busy      (busy),
        .range_err (range_err),
        .dup_err   (dup_err)
    );

    typedef struct {
        bit rdy;
        int cnt;
        bit done;
        bit busy;
        bit rerr;
        bit derr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Launch-level model: phase 0 idle, 1 collecting, 2 complete.
    int m_phase;
    int m_max;
    int m_cnt;
    bit m_rerr;
    bit m_derr;
    bit m_ret[int];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_phase = 0;
        m_max   = 0;
        m_cnt   = 0;
        m_rerr  = 0;
        m_derr  = 0;
        m_ret.delete();
    endtask

    // Drive one cycle of inputs and queue what the DUT must show for it.
    task automatic step(input bit en, input bit c, input bit v, input int tid, input int mx);
        exp_t e;
        @(posedge clk);
        #2;
        enable    = en;
        clr       = c;
        ret_valid = v;
        ret_tid   = TW'(tid);
        max_tid   = TW'(mx);
        e.rdy = (m_phase == 1) && en;
        if (c) begin
            m_reset();
        end else if (m_phase == 0) begin
            if (en) begin
                m_phase = 1;
                m_max   = mx;
                m_cnt   = 0;
                m_ret.delete();
            end
        end else if (m_phase == 1 && en && v) begin
            if (tid > m_max) begin
                m_rerr = 1;
            end else if (DUP_ON && m_ret.exists(tid)) begin
                m_derr = 1;
            end else begin
                m_ret[tid] = 1;
                m_cnt++;
                if (m_cnt == m_max + 1) m_phase = 2;
            end
        end
        e.cnt  = m_cnt;
        e.done = (m_phase == 2);
        e.busy = (m_phase == 1);
        e.rerr = m_rerr;
        e.derr = m_derr;
        sb_q.push_back(e);
    endtask

    // Monitor: pops one expectation per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ret_ready", int'(ret_ready), int'(e.rdy));
                @(posedge clk);
                #1;
                chk("ret_count", int'(ret_count), e.cnt);
                chk("all_done",  int'(all_done),  int'(e.done));
                chk("busy",      int'(busy),      int'(e.busy));
                chk("range_err", int'(range_err), int'(e.rerr));
                chk("dup_err",   int'(dup_err),   int'(e.derr));
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, int'(ret_ready), 0);
        chk({tag, "_count"}, int'(ret_count), 0);
        chk({tag, "_done"},  int'(all_done),  0);
        chk({tag, "_busy"},  int'(busy),      0);
        chk({tag, "_rerr"},  int'(range_err), 0);
        chk({tag, "_derr"},  int'(dup_err),   0);
    endtask

    // Let the monitor finish the last queued cycle, then pulse the async reset mid-cycle.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            chk({tag, "_sb_drained"}, sb_q.size(), 0);
            sb_q.delete();
        end
        enable    = 1'b1;
        ret_valid = 1'b1;
        clr       = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk_zero(tag);
        enable    = 1'b0;
        ret_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int seq4[4];
        int perm[TOTAL];
        int tmp;
        int j;
        int mx;

        m_reset();
        rst_n     = 1'b0;
        enable    = 1'b0;
        clr       = 1'b0;
        ret_valid = 1'b0;
        ret_tid   = '0;
        max_tid   = '0;
        #1;
        chk_zero("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Four TIDs out of order, back to back; DONE must hold until clr.
        seq4 = '{2, 0, 3, 1};
        step(1, 0, 0, 0, 3);
        foreach (seq4[i]) step(1, 0, 1, seq4[i], 3);
        step(1, 0, 1, 0, 3);
        step(1, 0, 0, 0, 3);
        step(0, 1, 0, 0, 0);
        idle(1);

        // Same TID twice.
        step(1, 0, 0, 0, 3);
        step(1, 0, 1, 1, 3);
        step(1, 0, 1, 1, 3);
        step(1, 0, 0, 0, 3);
        step(0, 1, 0, 0, 0);

        // Out-of-range TID.
        step(1, 0, 0, 0, 3);
        step(1, 0, 1, 7, 3);
        step(1, 0, 0, 0, 3);
        step(0, 1, 0, 0, 0);

        // Clear with a retirement presented.
        step(1, 0, 0, 0, 7);
        for (int t = 0; t < 5; t++) step(1, 0, 1, t, 7);
        step(1, 1, 1, 5, 7);
        step(0, 0, 1, 6, 7);
        idle(1);

        // Enable dropped for three cycles mid-launch, max_tid input wiggled (must stay latched).
        step(1, 0, 0, 0, 5);
        step(1, 0, 1, 0, 1);
        step(1, 0, 1, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 2, 0);
        for (int t = 2; t <= 5; t++) step(1, 0, 1, t, 9);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // Reset in the middle of a launch.
        step(1, 0, 0, 0, 7);
        step(1, 0, 1, 3, 7);
        step(1, 0, 1, 4, 7);
        async_reset("midrst");
        idle(1);

        // Random launches.
        for (int l = 0; l < 8; l++) begin
            mx = $urandom_range(0, 15);
            step(1, 0, 0, 0, mx);
            for (int k = 0; k < 50; k++) begin
                step($urandom_range(0, 9) != 0, 1'b0, $urandom_range(0, 9) < 7,
                     $urandom_range(0, mx + 2), $urandom_range(0, TOTAL - 1));
            end
            step($urandom_range(0, 1), 1'b1, $urandom_range(0, 1), 0, 0);
        end

        // Full-size launch in a shuffled order.
        for (int i = 0; i < TOTAL; i++) perm[i] = i;
        for (int i = TOTAL - 1; i > 0; i--) begin
            j       = $urandom_range(0, i);
            tmp     = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        step(1, 0, 0, 0, TOTAL - 1);
        for (int i = 0; i < TOTAL; i++) step(1, 0, 1, perm[i], TOTAL - 1);
        step(1, 0, 0, 0, 0);
        async_reset("endrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
